// File: rtl/prescaled_updown_counter_pkg.sv
// Shared constants for the prescaled up/down counter.
//   dir_e  : count direction as presented on up_down
//   mode_e : bound behaviour as presented on sat_mode
package prescaled_updown_counter_pkg;

    typedef enum logic {
        COUNT_DOWN = 1'b0,
        COUNT_UP   = 1'b1
    } dir_e;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

endpackage

// File: rtl/counter_prescaler.sv
// Programmable enable prescaler: emits tick once every prescale+1 enabled cycles.
//   clk      : clock, rising edge
//   reset_n  : asynchronous active-low reset
//   sync_clr : synchronous restart of the prescale count
//   enable   : advances the prescale count; tick is only ever high with enable
//   prescale : divisor minus one
//   tick     : combinational step request for the current edge
module counter_prescaler #(
    parameter int unsigned PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  sync_clr,
    input  logic                  enable,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] pre_cnt_q;
    logic [PRESCALE_W-1:0] pre_cnt_d;

    always_comb begin
        // >= rather than == so that lowering prescale while pre_cnt is
        // already above it fires immediately instead of wrapping round.
        tick      = enable && (pre_cnt_q >= prescale);
        pre_cnt_d = pre_cnt_q;
        if (sync_clr) begin
            pre_cnt_d = '0;
        end else if (tick) begin
            pre_cnt_d = '0;
        end else if (enable) begin
            pre_cnt_d = pre_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt_q <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
        end
    end

endmodule

// File: rtl/prescaled_updown_counter.sv
// Prescaled up/down counter with programmable modulus, wrap/saturate,
// parallel load, compare match and sticky overflow/underflow flags.
//   clk, reset_n      : clock (rising) and asynchronous active-low reset
//   clear, load       : synchronous clear / parallel load (clear has priority)
//   load_value        : load data, clamped to MAX_VALUE
//   enable, prescale  : step once every prescale+1 enabled cycles
//   up_down, sat_mode : direction (1 = up) and bound mode (1 = saturate)
//   compare_value     : reference for match
//   sticky_clear      : clears ovf_sticky / unf_sticky
//   count, step       : registered count and one-cycle step indication
//   ovf_pulse/unf_pulse, ovf_sticky/unf_sticky : bound events, pulsed and sticky
//   match             : combinational count == compare_value
module prescaled_updown_counter
    import prescaled_updown_counter_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned MAX_VALUE  = (2 ** WIDTH) - 1,
    parameter int unsigned PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_value,
    input  logic                  enable,
    input  logic                  up_down,
    input  logic                  sat_mode,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [WIDTH-1:0]      compare_value,
    input  logic                  sticky_clear,
    output logic [WIDTH-1:0]      count,
    output logic                  step,
    output logic                  ovf_pulse,
    output logic                  unf_pulse,
    output logic                  match,
    output logic                  ovf_sticky,
    output logic                  unf_sticky
);

    localparam logic [WIDTH-1:0] MAX_C = MAX_VALUE[WIDTH-1:0];

    logic             tick;
    logic [WIDTH-1:0] count_q, count_d;
    logic             step_q, step_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             ovf_sticky_q, ovf_sticky_d;
    logic             unf_sticky_q, unf_sticky_d;

    counter_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk      (clk),
        .reset_n  (reset_n),
        .sync_clr (clear | load),
        .enable   (enable),
        .prescale (prescale),
        .tick     (tick)
    );

    always_comb begin
        count_d = count_q;
        step_d  = 1'b0;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d = (load_value > MAX_C) ? MAX_C : load_value;
        end else if (tick) begin
            step_d = 1'b1;
            // Bound checks precede the +/-1 so the arithmetic never leaves WIDTH bits.
            if (up_down == COUNT_UP) begin
                if (count_q >= MAX_C) begin
                    ovf_d   = 1'b1;
                    count_d = (sat_mode == MODE_SAT) ? MAX_C : '0;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end else begin
                if (count_q == '0) begin
                    unf_d   = 1'b1;
                    count_d = (sat_mode == MODE_SAT) ? '0 : MAX_C;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
        end

        // A new event on the same edge as sticky_clear keeps the flag set.
        ovf_sticky_d = ovf_d | (ovf_sticky_q & ~sticky_clear);
        unf_sticky_d = unf_d | (unf_sticky_q & ~sticky_clear);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q      <= '0;
            step_q       <= 1'b0;
            ovf_q        <= 1'b0;
            unf_q        <= 1'b0;
            ovf_sticky_q <= 1'b0;
            unf_sticky_q <= 1'b0;
        end else begin
            count_q      <= count_d;
            step_q       <= step_d;
            ovf_q        <= ovf_d;
            unf_q        <= unf_d;
            ovf_sticky_q <= ovf_sticky_d;
            unf_sticky_q <= unf_sticky_d;
        end
    end

    assign count      = count_q;
    assign step       = step_q;
    assign ovf_pulse  = ovf_q;
    assign unf_pulse  = unf_q;
    assign ovf_sticky = ovf_sticky_q;
    assign unf_sticky = unf_sticky_q;
    assign match      = (count_q == compare_value);

endmodule
